// File: rtl/tlul_host_initiator.sv
// TL-UL host initiator: valid/ready register access to TL-UL A/D channels.
// Optional response watchdog enabled by defining TLUL_HOST_TIMEOUT_EN.
package tlul_pkg;

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpAccessAck  = 3'd0;
  localparam logic [2:0] OpAckData    = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_initiator
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [7:0]  SourceBase     = 8'd0,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [7:0]  rsp_source_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i,
  output logic        busy_o,
  output logic [7:0]  stray_cnt_o,
  output logic        timeout_o
);

  localparam int unsigned MO = MaxOutstanding;

  logic          a_valid_q, a_valid_d;
  logic [2:0]    a_opcode_q, a_opcode_d;
  logic [7:0]    a_source_q, a_source_d;
  logic [31:0]   a_address_q, a_address_d;
  logic [3:0]    a_mask_q, a_mask_d;
  logic [31:0]   a_data_q, a_data_d;
  logic [MO-1:0] pending_q, pending_d;
  logic [MO-1:0] exp_data_q, exp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    rsp_source_q, rsp_source_d;
  logic [7:0]    stray_q, stray_d;
  logic          to_d;

  logic          req_ready, req_acc;
  logic          d_ready, d_acc;
  logic [7:0]    d_idx, alloc_idx;
  logic          free_found;
  logic [MO-1:0] hit_vec, alloc_vec;
  logic          hit, exp_hit, got_data;

  always_comb begin
    free_found = 1'b0;
    alloc_idx  = 8'd0;
    for (int i = 0; i < int'(MO); i++) begin
      if (!pending_q[i] && !free_found) begin
        free_found = 1'b1;
        alloc_idx  = 8'(i);
      end
    end
  end

  assign req_ready = !a_valid_q && !(&pending_q);
  assign req_acc   = req_valid_i && req_ready;
  assign d_ready   = !rst && (!rsp_valid_q || rsp_ready_i);
  assign d_acc     = tl_i.d_valid && d_ready;
  assign d_idx     = tl_i.d_source - SourceBase;
  assign got_data  = (tl_i.d_opcode == OpAckData);

  always_comb begin
    hit_vec   = '0;
    alloc_vec = '0;
    for (int i = 0; i < int'(MO); i++) begin
      hit_vec[i]   = d_acc && (d_idx == 8'(i)) && pending_q[i];
      alloc_vec[i] = req_acc && (alloc_idx == 8'(i));
    end
  end

  assign hit     = |hit_vec;
  assign exp_hit = |(hit_vec & exp_data_q);

`ifdef TLUL_HOST_TIMEOUT_EN
  localparam logic [15:0] WdLast = 16'(TimeoutCycles - 1);
  logic [15:0] wd_q, wd_d;
  logic        to_q;
  logic        wd_fire;

  always_comb begin
    wd_d    = 16'd0;
    wd_fire = 1'b0;
    if ((|pending_q) && !d_acc) begin
      if (wd_q == WdLast) wd_fire = 1'b1;
      else                wd_d    = wd_q + 16'd1;
    end
  end
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    if (req_acc) begin
      a_valid_d   = 1'b1;
      a_source_d  = SourceBase + alloc_idx;
      a_address_d = {req_addr_i[31:2], 2'b00};
      a_mask_d    = req_we_i ? req_be_i : 4'hF;
      a_data_d    = req_we_i ? req_wdata_i : 32'd0;
      if (!req_we_i)              a_opcode_d = OpGet;
      else if (req_be_i == 4'hF)  a_opcode_d = OpPutFull;
      else                        a_opcode_d = OpPutPartial;
    end else if (a_valid_q && tl_i.a_ready) begin
      a_valid_d = 1'b0;
    end

    // Retired sources stay unavailable to the allocator until next cycle.
    pending_d  = (pending_q & ~hit_vec) | alloc_vec;
    if (wd_fire) pending_d = alloc_vec;
    exp_data_d = (exp_data_q & ~alloc_vec) | (alloc_vec & {MO{!req_we_i}});
    to_d       = wd_fire;

    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    rsp_source_d = rsp_source_q;
    if (hit) begin
      rsp_valid_d  = 1'b1;
      rsp_rdata_d  = got_data ? tl_i.d_data : 32'd0;
      rsp_err_d    = tl_i.d_error || (exp_hit != got_data);
      rsp_source_d = tl_i.d_source;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    stray_d = stray_q;
    if (d_acc && !hit && stray_q != 8'hFF) stray_d = stray_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q    <= 1'b0;
      a_opcode_q   <= 3'd0;
      a_source_q   <= 8'd0;
      a_address_q  <= 32'd0;
      a_mask_q     <= 4'd0;
      a_data_q     <= 32'd0;
      pending_q    <= '0;
      exp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
      rsp_source_q <= 8'd0;
      stray_q      <= 8'd0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_source_q   <= a_source_d;
      a_address_q  <= a_address_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      pending_q    <= pending_d;
      exp_data_q   <= exp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_source_q <= rsp_source_d;
      stray_q      <= stray_d;
    end
  end

`ifdef TLUL_HOST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= 16'd0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
  assign timeout_o = to_q;
`else
  logic unused_to;
  assign unused_to = to_d;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid_q;
    tl_o.a_opcode  = a_opcode_q;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = a_source_q;
    tl_o.a_address = a_address_q;
    tl_o.a_mask    = a_mask_q;
    tl_o.a_data    = a_data_q;
    tl_o.a_user    = 16'd0;
    tl_o.d_ready   = d_ready;
  end

  assign req_ready_o  = req_ready;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_source_o = rsp_source_q;
  assign busy_o       = (|pending_q) || a_valid_q;
  assign stray_cnt_o  = stray_q;

  logic unused_in;
  assign unused_in = ^{req_addr_i[1:0], tl_i.d_param, tl_i.d_size,
                       tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_initiator.sv
// Directed bench for tlul_host_initiator.
// Timeout checks run only when TLUL_HOST_TIMEOUT_EN is defined.
module tb_tlul_host_initiator;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [7:0]  rsp_source_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;
  logic        busy_o;
  logic [7:0]  stray_cnt_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlul_host_initiator #(
    .MaxOutstanding(4),
    .SourceBase(8'd0),
    .TimeoutCycles(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .rsp_source_o(rsp_source_o),
    .tl_o(tl_o),
    .tl_i(tl_i),
    .busy_o(busy_o),
    .stray_cnt_o(stray_cnt_o),
    .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_be_i    = be;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic dbeat(input logic [2:0] op, input logic [7:0] src,
                       input logic [31:0] data, input logic err);
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = op;
    tl_i.d_source = src;
    tl_i.d_data   = data;
    tl_i.d_error  = err;
    tick();
    tl_i.d_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] srcs [4];
    int n;
    srcs[0] = 8'd0; srcs[1] = 8'd1; srcs[2] = 8'd3; srcs[3] = 8'd2;
    rst = 1'b1;
    req_valid_i = 0; req_we_i = 0; req_addr_i = 0;
    req_wdata_i = 0; req_be_i = 0; rsp_ready_i = 0;
    tl_i = '0;
    tl_i.a_ready = 1'b1;
    tick();
    chk("rst_dready", 32'(tl_o.d_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_avalid", 32'(tl_o.a_valid), 0);
    chk("rst_rspv", 32'(rsp_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_stray", 32'(stray_cnt_o), 0);
    chk("rst_to", 32'(timeout_o), 0);
    chk("rst_rdy", 32'(req_ready_o), 1);

    // read
    req(1'b0, 32'h1003, 32'h0, 4'h0);
    chk("rd_av", 32'(tl_o.a_valid), 1);
    chk("rd_op", 32'(tl_o.a_opcode), 4);
    chk("rd_addr", tl_o.a_address, 32'h1000);
    chk("rd_mask", 32'(tl_o.a_mask), 32'hF);
    chk("rd_src", 32'(tl_o.a_source), 0);
    chk("rd_size", 32'(tl_o.a_size), 2);
    chk("rd_rdy0", 32'(req_ready_o), 0);
    tick();
    chk("rd_av0", 32'(tl_o.a_valid), 0);
    chk("rd_busy", 32'(busy_o), 1);
    dbeat(3'd1, 8'd0, 32'hDEADBEEF, 1'b0);
    chk("rd_rspv", 32'(rsp_valid_o), 1);
    chk("rd_data", rsp_rdata_o, 32'hDEADBEEF);
    chk("rd_err", 32'(rsp_err_o), 0);
    chk("rd_rsrc", 32'(rsp_source_o), 0);
    chk("rd_idle", 32'(busy_o), 0);
    consume();
    chk("rd_cons", 32'(rsp_valid_o), 0);

    // denied partial write
    req(1'b1, 32'h2000, 32'h1234, 4'h3);
    chk("pw_op", 32'(tl_o.a_opcode), 1);
    chk("pw_mask", 32'(tl_o.a_mask), 3);
    chk("pw_data", tl_o.a_data, 32'h1234);
    tick();
    dbeat(3'd0, 8'd0, 32'h0, 1'b1);
    chk("pw_err", 32'(rsp_err_o), 1);
    chk("pw_rdata", rsp_rdata_o, 0);
    consume();

    // full write answered with data: opcode mismatch
    req(1'b1, 32'h2004, 32'h55AA55AA, 4'hF);
    chk("fw_op", 32'(tl_o.a_opcode), 0);
    tick();
    dbeat(3'd1, 8'd0, 32'h77, 1'b0);
    chk("fw_mis", 32'(rsp_err_o), 1);
    consume();

    // write with no byte enables
    req(1'b1, 32'h2008, 32'h9, 4'h0);
    chk("z_op", 32'(tl_o.a_opcode), 1);
    chk("z_mask", 32'(tl_o.a_mask), 0);
    tick();
    dbeat(3'd0, 8'd0, 32'h0, 1'b0);
    chk("z_err", 32'(rsp_err_o), 0);
    consume();

    // fill all sources
    for (int i = 0; i < 4; i++) begin
      chk("fill_rdy", 32'(req_ready_o), 1);
      req(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0);
      chk("fill_src", 32'(tl_o.a_source), 32'(i));
      tick();
    end
    chk("full_rdy", 32'(req_ready_o), 0);
    dbeat(3'd1, 8'd2, 32'hA2, 1'b0);
    chk("ret_rdy", 32'(req_ready_o), 1);
    chk("ret_src", 32'(rsp_source_o), 2);
    chk("ret_data", rsp_rdata_o, 32'hA2);
    consume();
    req(1'b0, 32'h200, 32'h0, 4'h0);
    chk("reuse_src", 32'(tl_o.a_source), 2);
    tick();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dbeat(3'd1, srcs[i], 32'hB0 + 32'(srcs[i]), 1'b0);
      chk("ooo_v", 32'(rsp_valid_o), 1);
      chk("ooo_src", 32'(rsp_source_o), 32'(srcs[i]));
      chk("ooo_data", rsp_rdata_o, 32'hB0 + 32'(srcs[i]));
    end
    tick();
    rsp_ready_i = 1'b0;
    chk("ooo_busy", 32'(busy_o), 0);
    chk("ooo_rspv", 32'(rsp_valid_o), 0);

    // A backpressure
    tl_i.a_ready = 1'b0;
    req(1'b1, 32'h3004, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_av", 32'(tl_o.a_valid), 1);
      chk("bp_addr", tl_o.a_address, 32'h3004);
      chk("bp_data", tl_o.a_data, 32'hCAFEF00D);
      chk("bp_rdy", 32'(req_ready_o), 0);
    end
    tl_i.a_ready = 1'b1;
    tick();
    chk("bp_done", 32'(tl_o.a_valid), 0);
    dbeat(3'd0, 8'd0, 32'h0, 1'b0);
    chk("bp_rspv", 32'(rsp_valid_o), 1);
    chk("bp_dr0", 32'(tl_o.d_ready), 0);
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_dr1", 32'(tl_o.d_ready), 1);
    tick();
    rsp_ready_i = 1'b0;
    chk("bp_cons", 32'(rsp_valid_o), 0);

    // strays and mid-flight reset
    dbeat(3'd1, 8'd7, 32'h1, 1'b0);
    chk("st_rspv", 32'(rsp_valid_o), 0);
    chk("st_cnt", 32'(stray_cnt_o), 1);
    req(1'b0, 32'h400, 32'h0, 4'h0);
    tick();
    req(1'b0, 32'h404, 32'h0, 4'h0);
    chk("mf_busy", 32'(busy_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mf_av", 32'(tl_o.a_valid), 0);
    chk("mf_busy0", 32'(busy_o), 0);
    chk("mf_stray", 32'(stray_cnt_o), 0);
    chk("mf_rspv", 32'(rsp_valid_o), 0);
    dbeat(3'd1, 8'd0, 32'h5, 1'b0);
    dbeat(3'd1, 8'd1, 32'h6, 1'b0);
    chk("mf_cnt", 32'(stray_cnt_o), 2);
    chk("mf_norsp", 32'(rsp_valid_o), 0);

`ifdef TLUL_HOST_TIMEOUT_EN
    req(1'b0, 32'h500, 32'h0, 4'h0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (timeout_o) begin
        n = i;
        break;
      end
    end
    chk("to_cyc", 32'(n), 16);
    chk("to_busy", 32'(busy_o), 0);
    tick();
    chk("to_pulse", 32'(timeout_o), 0);
    dbeat(3'd1, 8'd0, 32'h8, 1'b0);
    chk("to_stray", 32'(stray_cnt_o), 3);
    chk("to_norsp", 32'(rsp_valid_o), 0);
`else
    n = 0;
    req(1'b0, 32'h500, 32'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (timeout_o) n++;
    end
    chk("to_off", 32'(n), 0);
    chk("to_hold", 32'(busy_o), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlul_host_initiator.md
Name: tlul_host_initiator

Overview:
TL-UL initiator that turns a simple valid/ready register-access interface into TL-UL A-channel requests and collects D-channel responses. It sits on the untrusted-master side of the access-control wrapper and talks to its host port. It tracks up to MaxOutstanding in-flight transactions by source ID. Denied accesses come back from the wrapper as d_error responses; this block reports them to its user per transaction.

Parameters:
MaxOutstanding, 4, maximum in-flight transactions; legal range 1..8; source IDs used are SourceBase..SourceBase+MaxOutstanding-1
SourceBase, 0, first a_source value; 8-bit
TimeoutCycles, 1024, response watchdog limit (used only with TLUL_HOST_TIMEOUT_EN); legal range 2..65535

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high (fixed, not the wrapper's async low reset)
req_valid_i  in  1  access request valid
req_ready_o  out  1  request accepted when valid&&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  32  byte address
req_wdata_i  in  32  write data
req_be_i  in  4  byte enables (writes)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_rdata_o  out  32  read data (0 for writes)
rsp_err_o  out  1  d_error set, or opcode mismatch
rsp_source_o  out  8  source ID of the completed transaction
tl_o  out  tl_h2d_t  TL-UL A channel plus d_ready
tl_i  in  tl_d2h_t  TL-UL D channel plus a_ready
busy_o  out  1  any transaction pending or A beat held
stray_cnt_o  out  8  saturating count of D beats with no matching pending source
timeout_o  out  1  one-cycle watchdog pulse (0 when feature compiled out)

Behaviour:
- Reset (rst=1 at posedge): tl_o.a_valid=0, tl_o.d_ready=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_source_o=0, busy_o=0, stray_cnt_o=0, timeout_o=0, pending mask=0. Reset mid-transaction drops all state. D beats that arrive after reset for sources issued before reset count as strays.
- req_ready_o = !a_valid_q && (popcount(pending) < MaxOutstanding). The path is combinational from registered state only and does not depend on req_valid_i.
- Source allocation: lowest free index i in pending_q; a_source = SourceBase+i. pending[i] is set in the same cycle the request is accepted.
- A channel: registered. On acceptance, a_valid rises at the next cycle and all A fields hold stable until a_valid&&a_ready.
  - Opcode: read → Get (4); write with be==4'hF → PutFullData (0); other writes → PutPartialData (1).
  - a_size=2. a_address={addr[31:2],2'b00}. a_mask=be for writes, 4'hF for reads. a_data=wdata for writes, 0 for reads. a_param=0. a_user=default.
  - Minimum latency: request accepted at cycle N → a_valid at N+1.
- Write with be==0: still issued as PutPartialData with mask 0.
- One-entry response buffer: tl_o.d_ready = !rsp_valid_o || rsp_ready_i (bypass-free, registered output).
- On d_valid&&d_ready, let idx = d_source-SourceBase.
  - idx in range and pending[idx]=1: clear pending[idx] and load the response buffer.
    - rsp_rdata = d_data for AccessAckData, else 0.
    - rsp_err = d_error || (Get expected AccessAckData but received AccessAck) || (Put expected AccessAck but received AccessAckData).
    - rsp_source = d_source.
    - The expected opcode per source is stored at allocation.
  - Otherwise (stray): beat consumed, no response produced, stray_cnt increments and saturates at 255.
- Response latency: D beat at cycle M → rsp_valid_o at M+1.
- Simultaneous allocation and retirement in the same cycle: both apply. The allocator uses pending_q, so the retiring source is not reused until the next cycle.
- Responses return in D-channel order, which may differ from request order. Ordering is identified by rsp_source_o.
- busy_o = |pending_q || a_valid_q.

Optional Feature:
TLUL_HOST_TIMEOUT_EN:
- Defined:
  - A 16-bit watchdog counts cycles while |pending_q=1 and no D beat is accepted.
  - The counter clears on any accepted D beat or when pending is empty.
  - When the count reaches TimeoutCycles-1: pending is cleared, timeout_o pulses for 1 cycle, and the counter clears.
  - Later D beats for the retired sources count as strays.
  - An A beat still held is not affected and still completes its handshake.
- Undefined: no watchdog logic; timeout_o is tied to 0.

Test Plan:
- Read with a_ready=1: req addr=0x1003, we=0 → next cycle a_valid, opcode=4, address=0x1000, mask=F, source=0. D beat AccessAckData, data=0xDEADBEEF → rsp_rdata=0xDEADBEEF, err=0, source=0.
- Partial write denied by wrapper: we=1, be=4'h3, data=0x1234 → opcode=1, mask=3. D beat AccessAck with d_error=1 → rsp_err=1.
- Fill: 4 back-to-back reads with no D responses → sources 0,1,2,3 issued and req_ready_o=0 after the 4th. Respond to source 2 → req_ready_o=1, next request reuses source 2.
- Backpressure: a_ready=0 for 5 cycles → A fields stable, req_ready_o=0. With rsp_ready_i=0 and rsp_valid_o=1 → d_ready=0.
- Stray: D beat with d_source=7 while nothing is pending → no rsp_valid_o, stray_cnt=1. Reset mid-flight with 2 pending → all outputs at reset values; later D beats raise stray_cnt.
- With TLUL_HOST_TIMEOUT_EN and TimeoutCycles=16: one read with no response → timeout_o pulses exactly 16 cycles after pending set, busy_o=0 the cycle after; a late response increments stray_cnt.
